uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver that recovers start/data/stop frames from a single idle-high line and presents each received word on a parallel valid/ready output. It is the receive end of the team's serial link, counterpart to the load-and-shift transmitter (idle-high line, start bit low, stop bit high, LSB first). Bit timing comes from an internal per-bit cycle counter; line input is synchronised and mid-bit sampled.

## Interface
- DATA_WIDTH, 8, data bits per frame (1..32)
- CLKS_PER_BIT, 16, clk cycles per bit period; even, ≥4
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- serialIn  input  1  serial line, idle high, asynchronous to clk
- rxReady  input  1  consumer accepts rxData when high with rxValid
- rxData  output  DATA_WIDTH  received word, bit 0 = first data bit on line
- rxValid  output  1  rxData holds an unconsumed word
- frameError  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: frame completed while rxValid still high
- parityError  output  1  one-cycle pulse: parity mismatch (0 when parity compiled out)

## Operation
- serialIn passes through 2-flop synchroniser (both reset to 1); all logic uses synchronised value `rxs` and its 1-cycle delayed copy.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: on `rxs`==0 and delayed copy ==1 → START, bit counter cleared. A line held low (break) never re-enters START until it returns high.
- START: at CLKS_PER_BIT/2 cycles after entry sample `rxs`; 0 → DATA, 1 → IDLE (false start, no flags).
- DATA: sample every CLKS_PER_BIT cycles; shift into data register LSB first; after DATA_WIDTH samples → PARITY or STOP.
- STOP: sample once after CLKS_PER_BIT cycles; return to IDLE the next cycle regardless of value (allows back-to-back frames half a bit early).
- Stop=1, no parity error: if rxValid low → rxData loaded, rxValid set; if rxValid high → overrun pulse, new word dropped, rxData unchanged.
- Stop=0: frameError pulse, word discarded, rxValid unchanged.
- Handshake: rxValid && rxReady at a clock edge clears rxValid. Load and clear in the same cycle: load wins (rxValid stays 1, new data).
- rxData stable while rxValid high.

## Timing
- Reset values: rxData 0, rxValid 0, frameError 0, overrun 0, parityError 0, state IDLE, synchroniser 1.
- Reset assertion mid-frame aborts immediately; after release, receiver waits for a fresh high→low edge.
- START entered at the 2nd clk edge after serialIn falls (setup met).
- Stop sample at START entry + CLKS_PER_BIT/2 + (DATA_WIDTH+1)·CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity); rxValid/flags register on the following edge.
- Defaults, no parity: serialIn falls before edge 0 → START at edge 2, stop sample edge 154, rxValid high after edge 155.
- Error/overrun pulses exactly one cycle wide.

## Configuration
- UART_RX_PARITY_EN defined: one even-parity bit follows data; PARITY state samples it CLKS_PER_BIT after last data sample; XOR of data and parity bit ≠0 → parityError pulse at frame end, word discarded, rxValid unchanged (frameError may pulse in same cycle if stop also bad).
- Not defined: no PARITY state, frames are start+DATA_WIDTH+stop, parityError tied 0.

## Test plan
- Defaults, rxReady=1, send 0xA5 at exact CLKS_PER_BIT → rxData=0xA5, rxValid high one cycle, after edge 155 relative to fall.
- Send 0x3C then 0xC3 back-to-back, rxReady=0 → first held, second frame asserts overrun one cycle, rxData stays 0x3C; rxReady=1 then clears rxValid.
- Glitch low for 4 cycles on idle line → no state beyond START, no rxValid, no flags.
- Frame 0x55 with stop bit driven 0 → frameError one-cycle pulse, rxValid stays 0; line held low 500 cycles then released → no further frames.
- Assert reset mid-data of frame 0xFF, release, send 0x81 → only 0x81 received, all outputs 0 during reset.
- With UART_RX_PARITY_EN: 0x07 with parity 1 → accepted; 0x07 with parity 0 → parityError pulse, no rxValid.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, valid/ready output.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serialIn,
  input  logic                  rxReady,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  output logic                  frameError,
  output logic                  overrun,
  output logic                  parityError
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  sync_q, rxs_q, rxs_dly_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  done_q, done_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  frame_perr;
  logic [DATA_WIDTH:0]   shift_ext;

  // Synchroniser resets high so reset release on an idle line looks idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      sync_q    <= serialIn;
      rxs_q     <= sync_q;
      rxs_dly_q <= rxs_q;
    end
  end

  assign shift_ext = {rxs_q, shift_q};

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d, perr_out_q, perr_out_d;
  assign frame_perr  = perr_q;
  assign parityError = perr_out_q;
`else
  assign frame_perr  = 1'b0;
  assign parityError = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs_q && rxs_dly_q) begin
          state_d = StStart;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_d   = 1'b0;
          perr_d  = 1'b0;
`endif
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = shift_ext[DATA_WIDTH:1];
          bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ rxs_q;
          if (bit_q == BitLast) state_d = StParity;
`else
          if (bit_q == BitLast) state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          perr_d  = par_q ^ rxs_q;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          stop_d  = rxs_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame result is resolved one cycle after the stop sample.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q && !rxReady;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_out_d = done_q && perr_q;
`endif
    if (done_q) begin
      ferr_d = !stop_q;
      if (stop_q && !frame_perr) begin
        if (valid_q) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign rxData     = data_q;
  assign rxValid    = valid_q;
  assign frameError = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames scored
// against a frame-level model of accepted words and error pulses.
module tb_uart_rx;
  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          serialIn;
  logic          rxReady;
  logic [DW-1:0] rxData;
  logic          rxValid;
  logic          frameError;
  logic          overrun;
  logic          parityError;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serialIn   (serialIn),
    .rxReady    (rxReady),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .frameError (frameError),
    .overrun    (overrun),
    .parityError(parityError)
  );

  // Observed behaviour: every new word and every pulse, plus any pulse longer than a cycle.
  logic [DW-1:0] got_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, wide_cnt = 0;
  logic pv = 1'b0, pf = 1'b0, po = 1'b0, pp = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (rxValid && !pv) got_q.push_back(rxData);
      if (frameError) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (parityError) perr_cnt++;
      if ((frameError && pf) || (overrun && po) || (parityError && pp)) wide_cnt++;
    end
    pv = rxValid;
    pf = frameError;
    po = overrun;
    pp = parityError;
  end

  // Frame-level model: what each completed frame should produce.
  logic [DW-1:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  bit mvalid = 1'b0;

  task automatic model_frame(input logic [DW-1:0] d, input bit stop_b, input bit par_flip);
    bit par_bad;
    par_bad = (PB == 1) && par_flip;
    if (par_bad) exp_perr++;
    if (!stop_b) exp_ferr++;
    if (stop_b && !par_bad) begin
      if (mvalid) exp_ovr++;
      else begin
        exp_q.push_back(d);
        mvalid = 1'b1;
      end
    end
    if (rxReady) mvalid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit stop_b, input bit par_flip,
                      input bit idle_after);
    serialIn = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < int'(DW); i++) begin
      serialIn = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PB != 0) begin
      serialIn = (^d) ^ par_flip;
      repeat (CPB) @(negedge clk);
    end
    serialIn = stop_b;
    repeat (CPB) @(negedge clk);
    serialIn = idle_after;
  endtask

  task automatic frame(input logic [DW-1:0] d, input bit stop_b, input bit par_flip);
    send(d, stop_b, par_flip, 1'b1);
    model_frame(d, stop_b, par_flip);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    check({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    check({tag, "_perr"}, perr_cnt, exp_perr);
    check({tag, "_width"}, wide_cnt, 0);
    check({tag, "_valid"}, 32'(rxValid), 32'(mvalid));
  endtask

  initial begin
    logic [DW-1:0] d;
    int gap;
    bit sb, pf_r;

    reset    = 1'b0;
    serialIn = 1'b1;
    rxReady  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rxData), 0);
    check("rst_valid", 32'(rxValid), 0);
    check("rst_ferr", 32'(frameError), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_perr", 32'(parityError), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Exact latency: valid appears after edge 155 (+ one bit with parity), for one cycle.
    fork
      send(8'hA5, 1'b1, 1'b0, 1'b1);
      begin
        repeat (155 + CPB * PB) @(posedge clk);
        #1 check("lat_before", 32'(rxValid), 0);
        @(posedge clk);
        #1 check("lat_valid", 32'(rxValid), 1);
        check("lat_data", 32'(rxData), 32'h0000_00A5);
        @(posedge clk);
        #1 check("lat_clear", 32'(rxValid), 0);
      end
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_all("first");

    // Random frames with occasional bad stop/parity bits and random gaps.
    for (int n = 0; n < 10; n++) begin
      d    = DW'($urandom);
      sb   = ($urandom_range(0, 3) != 0);
      pf_r = ($urandom_range(0, 3) == 0);
      gap  = (sb && !pf_r) ? $urandom_range(0, 12) : $urandom_range(2, 12);
      frame(d, sb, pf_r);
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_all("random");

    // Overrun: back-to-back frames with consumer stalled.
    rxReady = 1'b0;
    frame(8'h3C, 1'b1, 1'b0);
    frame(8'hC3, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ovr_data", 32'(rxData), 32'h0000_003C);
    check_all("overrun");
    rxReady = 1'b1;
    @(negedge clk);
    mvalid = 1'b0;
    check("ovr_release", 32'(rxValid), 0);

    // Short glitch on idle line is a false start.
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    serialIn = 1'b1;
    repeat (200) @(negedge clk);
    check_all("glitch");

    // Bad stop bit then line held low (break) for 500 cycles.
    send(8'h55, 1'b0, 1'b0, 1'b0);
    model_frame(8'h55, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    serialIn = 1'b1;
    repeat (200) @(negedge clk);
    check_all("break");

    // Reset mid-frame while a word is pending.
    rxReady = 1'b0;
    frame(8'h5A, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("pend_valid", 32'(rxValid), 1);
    fork
      send(8'hFF, 1'b1, 1'b0, 1'b1);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_data", 32'(rxData), 0);
        check("mid_rst_valid", 32'(rxValid), 0);
        check("mid_rst_flags", {29'd0, frameError, overrun, parityError}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join
    mvalid  = 1'b0;
    rxReady = 1'b1;
    repeat (10) @(negedge clk);
    frame(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_all("after_rst");

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_all("par_good");
    frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_all("par_bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
